// File: rtl/operand_reg_bank_if.sv
// Word-serial load/unload bus of the operand register bank.
// The master side is the host or operand memory, the slave side is the register bank.
interface operand_reg_bank_if #(
    parameter int WORD = 32
) ();
    logic            wr_valid;
    logic [WORD-1:0] wr_data;
    logic            wr_ready;
    logic            rd_start;
    logic            rd_valid;
    logic [WORD-1:0] rd_data;
    logic            rd_ready;

    modport master (
        output wr_valid, wr_data, rd_start, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, rd_start, rd_ready,
        output wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/operand_reg_bank.sv
// RSA operand register: parallel load, word-serial load/unload (LS word first),
// one-bit right shift for exponent scanning, and synchronous clear.
module operand_reg_bank #(
    parameter int WIDTH = 4096,
    parameter int WORD  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic [WIDTH-1:0]    inp,
    input  logic                shr,
    operand_reg_bank_if.slave   bus,
    output logic [WIDTH-1:0]    outp,
    output logic                lsb,
    output logic                loaded,
    output logic                rd_done,
    output logic                busy
);
    localparam int NWORDS = WIDTH / WORD;
    localparam int CW     = $clog2(NWORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        UNLOAD = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [WIDTH-1:0] data_r, data_s;
    logic             loaded_r, loaded_s;
    logic             rd_done_r, rd_done_s;
    logic             wr_ready_s;
    logic             wr_hs_s;
    logic             last_s;
    int               word_base_s;

    assign word_base_s = int'(cnt_r) * WORD;
    assign last_s      = (cnt_r == CW'(NWORDS - 1));
    assign wr_hs_s     = bus.wr_valid && wr_ready_s;

    // Write side is open whenever an unload is not in progress.
    always_comb begin
        case (state_r)
            IDLE:    wr_ready_s = 1'b1;
            LOAD:    wr_ready_s = 1'b1;
            UNLOAD:  wr_ready_s = 1'b0;
            default: wr_ready_s = 1'b0;
        endcase
    end

    // Next-state logic; the if-chain order is the per-cycle action priority.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        data_s    = data_r;
        loaded_s  = 1'b0;
        rd_done_s = 1'b0;
        if (clr) begin
            data_s  = {WIDTH{1'b0}};
            cnt_s   = {CW{1'b0}};
            state_s = IDLE;
        end else if (en) begin
            data_s  = inp;
            cnt_s   = {CW{1'b0}};
            state_s = IDLE;
        end else if (wr_hs_s) begin
            data_s[word_base_s +: WORD] = bus.wr_data;
            if (last_s) begin
                cnt_s    = {CW{1'b0}};
                state_s  = IDLE;
                loaded_s = 1'b1;
            end else begin
                cnt_s   = cnt_r + CW'(1);
                state_s = LOAD;
            end
        end else if (state_r == UNLOAD) begin
            if (bus.rd_ready && last_s) begin
                cnt_s     = {CW{1'b0}};
                state_s   = IDLE;
                rd_done_s = 1'b1;
            end else if (bus.rd_ready) begin
                cnt_s = cnt_r + CW'(1);
            end else begin
                cnt_s = cnt_r;
            end
        end else if (state_r == IDLE && bus.rd_start) begin
            cnt_s   = {CW{1'b0}};
            state_s = UNLOAD;
        end else if (state_r == IDLE && shr) begin
            data_s = {1'b0, data_r[WIDTH-1:1]};
        end else begin
            state_s = state_r;
        end
    end

    // State, counter, operand and completion-pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            data_r    <= {WIDTH{1'b0}};
            loaded_r  <= 1'b0;
            rd_done_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            data_r    <= data_s;
            loaded_r  <= loaded_s;
            rd_done_r <= rd_done_s;
        end
    end

    assign outp         = data_r;
    assign lsb          = data_r[0];
    assign loaded       = loaded_r;
    assign rd_done      = rd_done_r;
    assign busy         = (state_r != IDLE);
    assign bus.wr_ready = wr_ready_s;
    assign bus.rd_valid = (state_r == UNLOAD);
    assign bus.rd_data  = (state_r == UNLOAD) ? data_r[word_base_s +: WORD] : {WORD{1'b0}};
endmodule

// File: tb/tb_operand_reg_bank.sv
// Directed bench for operand_reg_bank: a 64/16 instance for the detailed cases
// and a 4096/32 instance for the full-size load, unload and shift-out.
module tb_operand_reg_bank;
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0, en = 1'b0, shr = 1'b0;
    logic [63:0]   inp = 64'h0;
    logic [63:0]   outp;
    logic          lsb, loaded, rd_done, busy;

    logic          b_clr = 1'b0, b_en = 1'b0, b_shr = 1'b0;
    logic [4095:0] b_inp = {4096{1'b0}};
    logic [4095:0] b_outp;
    logic          b_lsb, b_loaded, b_rd_done, b_busy;
    logic [4095:0] ref_v;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] V = 64'h0123_4567_89AB_CDEF;
    logic [15:0] w [4] = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};

    operand_reg_bank_if #(.WORD(16)) bus ();
    operand_reg_bank_if #(.WORD(32)) bus_b ();

    operand_reg_bank #(.WIDTH(64), .WORD(16)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .inp(inp), .shr(shr),
        .bus(bus), .outp(outp), .lsb(lsb), .loaded(loaded),
        .rd_done(rd_done), .busy(busy)
    );

    operand_reg_bank #(.WIDTH(4096), .WORD(32)) u_big (
        .clk(clk), .rst(rst), .clr(b_clr), .en(b_en), .inp(b_inp), .shr(b_shr),
        .bus(bus_b), .outp(b_outp), .lsb(b_lsb), .loaded(b_loaded),
        .rd_done(b_rd_done), .busy(b_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.wr_valid = 1'b0; bus.wr_data = 16'h0; bus.rd_start = 1'b0; bus.rd_ready = 1'b0;
        bus_b.wr_valid = 1'b0; bus_b.wr_data = 32'h0; bus_b.rd_start = 1'b0; bus_b.rd_ready = 1'b0;

        // reset and idle
        #2;
        check("rst_outp", outp, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();
        check("idle_wr_ready", {63'h0, bus.wr_ready}, 64'h1);
        check("idle_rd_valid", {63'h0, bus.rd_valid}, 64'h0);
        check("idle_rd_data", {48'h0, bus.rd_data}, 64'h0);
        check("idle_loaded", {63'h0, loaded}, 64'h0);

        // parallel load then clear
        en = 1'b1; inp = V;
        tick();
        en = 1'b0;
        check("en_outp", outp, V);
        check("en_lsb", {63'h0, lsb}, 64'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_outp", outp, 64'h0);

        // back-to-back serial load
        for (int k = 0; k < 4; k++) begin
            bus.wr_valid = 1'b1; bus.wr_data = w[k];
            tick();
            check("b2b_loaded", {63'h0, loaded}, {63'h0, k == 3});
            check("b2b_busy", {63'h0, busy}, {63'h0, k < 3});
        end
        bus.wr_valid = 1'b0;
        check("b2b_outp", outp, V);
        tick();
        check("b2b_loaded_end", {63'h0, loaded}, 64'h0);

        // serial load with three idle gaps: pulse lands 7 cycles in
        clr = 1'b1;
        tick();
        clr = 1'b0;
        begin
            logic [6:0] pat;
            int idx;
            pat = 7'b1001101;
            idx = 0;
            for (int i = 0; i < 7; i++) begin
                bus.wr_valid = pat[i];
                bus.wr_data  = pat[i] ? w[idx] : 16'hDEAD;
                tick();
                if (pat[i]) idx++;
                check("gap_loaded", {63'h0, loaded}, {63'h0, i == 6});
            end
        end
        bus.wr_valid = 1'b0;
        check("gap_outp", outp, V);
        tick();
        check("gap_loaded_end", {63'h0, loaded}, 64'h0);

        // serial unload with rd_ready 1,0,1,1,1; writes and shr must be ignored
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        shr = 1'b1; bus.wr_valid = 1'b1; bus.wr_data = 16'hFFFF;
        begin
            logic [4:0] rpat;
            int idx;
            rpat = 5'b11101;
            idx = 0;
            for (int i = 0; i < 5; i++) begin
                bus.rd_ready = rpat[i];
                check("ul_rd_valid", {63'h0, bus.rd_valid}, 64'h1);
                check("ul_rd_data", {48'h0, bus.rd_data}, {48'h0, w[idx]});
                check("ul_wr_ready", {63'h0, bus.wr_ready}, 64'h0);
                tick();
                if (rpat[i]) idx++;
                check("ul_rd_done", {63'h0, rd_done}, {63'h0, i == 4});
            end
        end
        shr = 1'b0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
        check("ul_outp", outp, V);
        check("ul_busy_end", {63'h0, busy}, 64'h0);
        tick();
        check("ul_rd_done_end", {63'h0, rd_done}, 64'h0);

        // right shift x3: lsb 1 -> 0 -> 1 -> 1
        en = 1'b1; inp = 64'h8000_0000_0000_000D;
        tick();
        en = 1'b0;
        check("shr_lsb0", {63'h0, lsb}, 64'h1);
        shr = 1'b1;
        tick();
        check("shr_lsb1", {63'h0, lsb}, 64'h0);
        tick();
        check("shr_lsb2", {63'h0, lsb}, 64'h1);
        tick();
        shr = 1'b0;
        check("shr_outp", outp, 64'h1000_0000_0000_0001);

        // en aborts a partial load; unwritten words keep prior contents
        en = 1'b1; inp = V;
        tick();
        en = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_data = 16'hA1A1;
        tick();
        bus.wr_data = 16'hB2B2;
        tick();
        check("part_outp", outp, 64'h0123_4567_B2B2_A1A1);
        en = 1'b1; inp = 64'h1111_2222_3333_4444; bus.wr_data = 16'hC3C3;
        tick();
        en = 1'b0;
        check("abort_outp", outp, 64'h1111_2222_3333_4444);
        check("abort_busy", {63'h0, busy}, 64'h0);
        check("abort_loaded", {63'h0, loaded}, 64'h0);
        bus.wr_data = 16'h5555;
        tick();
        check("restart_outp", outp, 64'h1111_2222_3333_5555);
        check("restart_busy", {63'h0, busy}, 64'h1);
        bus.wr_data = 16'h6666;
        tick();
        bus.wr_data = 16'h7777;
        tick();
        check("restart3_outp", outp, 64'h1111_7777_6666_5555);
        // en together with the final word: en wins, no pulse
        bus.wr_data = 16'h8888; en = 1'b1; inp = 64'hDEAD_BEEF_0000_0042;
        tick();
        en = 1'b0; bus.wr_valid = 1'b0;
        check("en_final_outp", outp, 64'hDEAD_BEEF_0000_0042);
        check("en_final_loaded", {63'h0, loaded}, 64'h0);
        check("en_final_busy", {63'h0, busy}, 64'h0);
        tick();
        check("en_final_loaded2", {63'h0, loaded}, 64'h0);

        // clr during unload
        en = 1'b1; inp = V;
        tick();
        en = 1'b0; bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0; bus.rd_ready = 1'b1;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0; bus.rd_ready = 1'b0;
        check("clr_ul_outp", outp, 64'h0);
        check("clr_ul_busy", {63'h0, busy}, 64'h0);
        check("clr_ul_rd_valid", {63'h0, bus.rd_valid}, 64'h0);
        check("clr_ul_rd_done", {63'h0, rd_done}, 64'h0);
        tick();
        check("clr_ul_rd_done2", {63'h0, rd_done}, 64'h0);

        // asynchronous reset in the middle of a load
        bus.wr_valid = 1'b1; bus.wr_data = 16'h1234;
        tick();
        bus.wr_data = 16'h5678;
        tick();
        bus.wr_valid = 1'b0;
        check("pre_rst_outp", outp, 64'h0000_0000_5678_1234);
        #2 rst = 1'b0;
        #1;
        check("async_rst_outp", outp, 64'h0);
        check("async_rst_busy", {63'h0, busy}, 64'h0);
        #10 rst = 1'b1;
        tick();
        check("post_rst_wr_ready", {63'h0, bus.wr_ready}, 64'h1);
        check("post_rst_loaded", {63'h0, loaded}, 64'h0);

        // full-size: 128-word random load
        for (int k = 0; k < 128; k++) begin
            logic [31:0] rw;
            rw = $urandom;
            ref_v[k*32 +: 32] = rw;
            bus_b.wr_valid = 1'b1; bus_b.wr_data = rw;
            tick();
        end
        bus_b.wr_valid = 1'b0;
        check("big_loaded", {63'h0, b_loaded}, 64'h1);
        check("big_outp", {63'h0, b_outp == ref_v}, 64'h1);

        // full-size unload
        bus_b.rd_start = 1'b1;
        tick();
        bus_b.rd_start = 1'b0; bus_b.rd_ready = 1'b1;
        for (int k = 0; k < 128; k++) begin
            check("big_rd_data", {32'h0, bus_b.rd_data}, {32'h0, ref_v[k*32 +: 32]});
            tick();
        end
        bus_b.rd_ready = 1'b0;
        check("big_rd_done", {63'h0, b_rd_done}, 64'h1);
        check("big_outp_kept", {63'h0, b_outp == ref_v}, 64'h1);

        // all-ones shifted out completely
        b_en = 1'b1; b_inp = {4096{1'b1}};
        tick();
        b_en = 1'b0; b_shr = 1'b1;
        repeat (4095) tick();
        check("big_shr_one", {63'h0, b_outp == 4096'd1}, 64'h1);
        tick();
        b_shr = 1'b0;
        check("big_shr_zero", {63'h0, b_outp == 4096'd0}, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/operand_reg_bank.md
# operand_reg_bank

Parametrised operand register for the RSA datapath, the next generation of the plain enable-load register. It adds three things on top of single-cycle parallel load. Word-serial load and unload over a valid/ready bus lets 4096-bit operands move through a narrow host or memory interface. A one-bit right shift supports exponent scanning in modular exponentiation. A synchronous clear is included. It sits between the host/operand memory and the modular multiplier, holding one operand (base, exponent, modulus or result).

## Interface
- WIDTH, 4096, operand width in bits
- WORD, 32, serial bus word width; WIDTH must be an integer multiple of WORD with NWORDS = WIDTH/WORD ≥ 2
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of register and control state
- en  in  1  parallel load strobe
- inp  in  WIDTH  parallel load data
- shr  in  1  shift register right by one bit (zero fill at MSB)
- wr_valid  in  1  serial write word valid
- wr_data  in  WORD  serial write word
- wr_ready  out  1  serial write accepted when high with wr_valid
- rd_start  in  1  begin serial unload
- rd_valid  out  1  rd_data valid
- rd_data  out  WORD  serial read word
- rd_ready  in  1  consumer accepts rd_data
- outp  out  WIDTH  register contents
- lsb  out  1  outp[0], combinational
- loaded  out  1  one-cycle pulse: serial load completed
- rd_done  out  1  one-cycle pulse: serial unload completed
- busy  out  1  state is LOAD or UNLOAD

## Operation
- States: IDLE, LOAD, UNLOAD. Word counter cnt has width clog2(NWORDS). Words are ordered LS-word first: word k occupies bits [k*WORD +: WORD].
- Priority per cycle: clr > en > serial write/read handshake > rd_start > shr.
- clr: outp←0, cnt←0, state←IDLE. Pending handshakes are dropped and no pulses are issued.
- en: outp←inp, cnt←0, state←IDLE. Any serial transfer in progress is aborted with no loaded/rd_done pulse.
- wr_ready = 1 in IDLE or LOAD, 0 in UNLOAD.
- Write handshake (wr_valid & wr_ready):
  - Word cnt←wr_data, cnt increments, and IDLE moves to LOAD.
  - On the word with cnt = NWORDS-1: cnt←0, state←IDLE, loaded=1 next cycle.
  - Words not yet written keep their prior values.
- rd_start in IDLE with no write handshake that cycle: state←UNLOAD, cnt←0. rd_start is ignored in LOAD and UNLOAD.
- UNLOAD:
  - rd_valid=1 and rd_data = word cnt of outp, both combinational.
  - On rd_ready, cnt increments.
  - On the last word: state←IDLE, cnt←0, rd_done=1 next cycle.
  - outp is not modified.
- shr: outp←{1'b0, outp[WIDTH-1:1]}, accepted only in IDLE and only when no higher-priority action occurs that cycle. It is ignored in LOAD and UNLOAD.
- rd_valid = 0 outside UNLOAD. rd_data is 0 outside UNLOAD.

## Timing
- Reset (rst=0, asynchronous):
  - outp=0, state=IDLE, cnt=0, loaded=0, rd_done=0, busy=0, rd_valid=0.
  - wr_ready=1 from the first cycle after deassertion.
- en, clr, shr and each accepted write are visible on outp the cycle after the edge that samples them.
- Serial load of NWORDS words back to back takes NWORDS cycles. loaded is asserted in cycle NWORDS+1 for exactly one cycle.
- Serial unload: the first word is valid the cycle after rd_start. With rd_ready held high, one word is transferred per cycle. rd_done follows the last handshake by one cycle.
- Reset mid-transfer returns to IDLE immediately. No pulse is issued.
- A write stall (wr_valid=0) in LOAD holds cnt and state indefinitely. No timeout.
- Simultaneous en with a final write word: en wins, and loaded is not pulsed.
- lsb tracks outp combinationally, so after shr it reflects the new bit in the next cycle.

## Test plan
(WIDTH=64, WORD=16 unless stated)
- Reset then idle: outp=0, wr_ready=1, rd_valid=0, busy=0; en with inp=64'h0123_4567_89AB_CDEF → outp=64'h0123_4567_89AB_CDEF next cycle.
- Serial load of words 16'hCDEF, 16'h89AB, 16'h4567, 16'h0123 back to back → outp=64'h0123_4567_89AB_CDEF, loaded pulses once in cycle 5. Repeat with wr_valid gaps → same result, pulse delayed by gap count.
- Serial unload of that value with rd_ready toggling 1,0,1,1,1 → rd_data sequence CDEF, 89AB, 4567, 0123, outp unchanged, rd_done one cycle after the last handshake, wr_ready=0 throughout UNLOAD.
- shr ×3 on 64'h8000_0000_0000_000D → lsb sequence 1,0,1, final outp=64'h1000_0000_0000_0001. shr asserted during UNLOAD → outp unchanged.
- Abort cases, each producing no loaded/rd_done pulse and returning to IDLE:
  - en during LOAD after 2 words → outp=inp, cnt=0.
  - clr during UNLOAD → outp=0.
  - rst low mid-LOAD → outp=0 asynchronously.
- WIDTH=4096, WORD=32: 128-word random serial load → outp matches the reference value. Unload returns identical words. Parallel en of all-ones followed by 4096 shr → outp=0.
